alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer-side counterpart of the pipeline ALU, sitting between ID and EX.
- Accepts decoded instruction fields and resolves forwarding and immediate selection.
- Generates the 3-bit ALU opcode and buffers up to two issued operations in a 2-entry skid queue.
- Presents registered alu_a/alu_b/alu_opc to the combinational ALU under a valid/ready handshake.

Parameters:
- N, 32, operand/result width.
- CNT_W, 8, width of the saturating illegal-op counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ID presents an operation.
- in_ready  output  1  stage can accept; equals (count < 2).
- alu_op  input  2  main-control class: 00 add, 01 sub, 10 R-type (use funct), 11 slt.
- funct  input  6  R-type function field.
- rs_data  input  N  register-file A operand.
- rt_data  input  N  register-file B operand.
- imm  input  N  sign-extended immediate.
- alu_src  input  1  1 selects imm as the B operand.
- fwd_a  input  2  A forwarding select: 00 rs_data, 01 ex_mem_res, 10 mem_wb_res, 11 rs_data.
- fwd_b  input  2  B forwarding select, same coding, against rt_data.
- ex_mem_res  input  N  EX/MEM forwarded value.
- mem_wb_res  input  N  MEM/WB forwarded value.
- flush  input  1  synchronous squash of all queued entries.
- out_valid  output  1  head entry valid.
- out_ready  input  1  EX consumes the head.
- alu_a  output  N  head A operand.
- alu_b  output  N  head B operand.
- alu_opc  output  3  head opcode.
- store_data  output  N  head forwarded rt value, for sw.
- illegal  output  1  head entry carried an unrecognised funct.
- illegal_cnt  output  CNT_W  saturating count of accepted illegal ops.

Behaviour:
- Reset (async, immediate):
  - count=0, both entries cleared, out_valid=0, in_ready=1.
  - alu_a=alu_b=store_data=0, alu_opc=000, illegal=0, illegal_cnt=0.
- Opcode decode, evaluated at capture:
  - alu_op 00→010, 01→110, 11→111.
  - alu_op 10 by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - Any other funct under alu_op 10 → opc 011 (ALU yields 0) with the illegal bit set in the entry.
- Operand selection at capture:
  - opA = fwd_a-selected value.
  - fwdB = fwd_b-selected value.
  - alu_b = alu_src ? imm : fwdB.
  - store_data = fwdB regardless of alu_src.
  - Forward values are sampled only in the push cycle; later changes to ex_mem_res or mem_wb_res do not affect queued entries.
- Push: in_valid && in_ready captures the entry at the tail.
- Pop: out_valid && out_ready retires the head.
- Latency: an operation accepted at edge k is visible on the outputs after edge k (1 cycle) when the queue was empty.
- Queue ordering: FIFO, head entry drives the outputs.
  - Outputs hold stable while out_valid && !out_ready.
  - When count=0, outputs keep their last values with out_valid=0.
- Simultaneous push and pop:
  - count=1: the head is replaced by the new entry, count stays 1.
  - count=2: cannot occur, since in_ready=0.
- Full (count=2): in_ready=0; in_valid is ignored with no side effects.
- flush:
  - Next edge: count=0, out_valid=0.
  - Any push or pop in the same cycle is discarded.
  - illegal_cnt is not changed by a flushed push.
  - flush has priority over all other events.
- illegal_cnt:
  - Increments on each accepted (non-flushed) push whose decode is illegal.
  - Saturates at 2^CNT_W−1; reset only by rst.
- Arithmetic: no arithmetic in this block; values pass through bit-exact, no width changes.
- Reset asserted mid-operation clears all queued entries immediately, with no partial retire.

Test Plan:
- R-type issue with empty queue, out_ready=1:
  - Stimulus: alu_op=10, funct=100010, rs_data=7, rt_data=3, fwd=00/00, alu_src=0.
  - Required: next cycle out_valid=1, alu_a=7, alu_b=3, alu_opc=110; retired the following edge.
- Forwarding and immediate:
  - Stimulus: fwd_a=01 with ex_mem_res=0x100, fwd_b=10 with mem_wb_res=0x55, alu_src=1, imm=0xFFFFFFFC, alu_op=00.
  - Required: alu_a=0x100, alu_b=0xFFFFFFFC, store_data=0x55, alu_opc=010.
- Backpressure:
  - Stimulus: out_ready=0, three back-to-back in_valid pushes A, B, C.
  - Required: in_ready drops after B, C is not accepted and is held by ID; releasing out_ready yields A then B in order, then C is accepted.
- Illegal funct:
  - Stimulus: alu_op=10, funct=000111.
  - Required: alu_opc=011, illegal=1, illegal_cnt 0→1.
  - Also: with CNT_W=2, five illegal pushes leave illegal_cnt=3.
- Flush:
  - Stimulus: count=2, flush asserted together with in_valid and out_ready.
  - Required: next cycle out_valid=0, in_ready=1, illegal_cnt unchanged.
- Async reset:
  - Stimulus: assert rst between clock edges with count=2.
  - Required: out_valid=0 and all outputs zero immediately, before the next edge.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Issue stage between ID and EX. It takes the decoded instruction fields,
// resolves operand forwarding and immediate selection, and generates the
// 3-bit ALU opcode. Each issued operation is buffered in a 2-entry skid
// queue. The head entry drives the registered operands presented to the
// combinational ALU under a valid/ready handshake.
//
// Parameters
//   N      operand / result width
//   CNT_W  width of the saturating illegal-op counter
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   in_valid, in_ready   ID-side handshake (in_ready = queue not full)
//   alu_op, funct        main-control class and R-type function field
//   rs_data, rt_data     register-file operands
//   imm, alu_src         sign-extended immediate and its B-operand select
//   fwd_a, fwd_b         forwarding selects (00/11 reg, 01 EX/MEM, 10 MEM/WB)
//   ex_mem_res           EX/MEM forwarded value
//   mem_wb_res           MEM/WB forwarded value
//   flush                synchronous squash of every queued entry
//   out_valid, out_ready EX-side handshake on the head entry
//   alu_a, alu_b         head operands
//   alu_opc              head opcode
//   store_data           head forwarded rt value, used by sw
//   illegal              head entry decoded an unrecognised funct
//   illegal_cnt          saturating count of accepted illegal ops
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [N-1:0]     rs_data,
    input  logic [N-1:0]     rt_data,
    input  logic [N-1:0]     imm,
    input  logic             alu_src,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [N-1:0]     ex_mem_res,
    input  logic [N-1:0]     mem_wb_res,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [2:0]       alu_opc,
    output logic [N-1:0]     store_data,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] sd;
        logic [2:0]   opc;
        logic         ill;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

    entry_t           new_entry;
    logic [N-1:0]     op_a;
    logic [N-1:0]     fwd_b_val;
    logic [2:0]       dec_opc;
    logic             dec_ill;
    logic             push;
    logic             pop;

    // Opcode decode. Unknown R-type functions issue as opcode 011 (ALU
    // produces zero) and carry the illegal flag down the pipe.
    always_comb begin
        dec_opc = 3'b011;
        dec_ill = 1'b0;
        case (alu_op)
            2'b00: dec_opc = 3'b010;
            2'b01: dec_opc = 3'b110;
            2'b11: dec_opc = 3'b111;
            default: begin
                case (funct)
                    6'b100000: dec_opc = 3'b010;
                    6'b100010: dec_opc = 3'b110;
                    6'b100100: dec_opc = 3'b000;
                    6'b100101: dec_opc = 3'b001;
                    6'b101010: dec_opc = 3'b111;
                    default: begin
                        dec_opc = 3'b011;
                        dec_ill = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Forwarding muxes. Code 11 falls back to the register-file value.
    always_comb begin
        case (fwd_a)
            2'b01:   op_a = ex_mem_res;
            2'b10:   op_a = mem_wb_res;
            default: op_a = rs_data;
        endcase
        case (fwd_b)
            2'b01:   fwd_b_val = ex_mem_res;
            2'b10:   fwd_b_val = mem_wb_res;
            default: fwd_b_val = rt_data;
        endcase
    end

    // The store value always takes the forwarded rt, even when the
    // immediate replaces it on the B operand.
    always_comb begin
        new_entry.a   = op_a;
        new_entry.b   = alu_src ? imm : fwd_b_val;
        new_entry.sd  = fwd_b_val;
        new_entry.opc = dec_opc;
        new_entry.ill = dec_ill;
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Queue next state. head_q is always the entry on the outputs; when the
    // queue drains it is left untouched so the outputs keep their last
    // values. Push+pop can only happen with one entry, where the new entry
    // simply replaces the head.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        ill_cnt_d = ill_cnt_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = new_entry;
                    end else begin
                        tail_d = new_entry;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    head_d = new_entry;
                end
                default: ;
            endcase
            if (push && new_entry.ill && (ill_cnt_q != CNT_MAX)) begin
                ill_cnt_d = ill_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= 2'd0;
            ill_cnt_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign alu_a       = head_q.a;
    assign alu_b       = head_q.b;
    assign store_data  = head_q.sd;
    assign alu_opc     = head_q.opc;
    assign illegal     = head_q.ill;
    assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Self-checking bench for alu_issue_stage. A queue-based reference model
// predicts the outputs from the instruction fields. Directed scenarios come
// first, followed by a randomized run. The DUT uses CNT_W=2 so that
// counter saturation is reachable.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    localparam int N       = 32;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [N-1:0]     rs_data;
    logic [N-1:0]     rt_data;
    logic [N-1:0]     imm;
    logic             alu_src;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [N-1:0]     ex_mem_res;
    logic [N-1:0]     mem_wb_res;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [2:0]       alu_opc;
    logic [N-1:0]     store_data;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    alu_issue_stage #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .alu_src(alu_src),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_mem_res(ex_mem_res), .mem_wb_res(mem_wb_res),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opc(alu_opc),
        .store_data(store_data), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [2:0]  opc;
        logic        ill;
    } refEntry_t;

    refEntry_t refQ[$];
    refEntry_t shown;
    int        refCnt;
    int        total = 0;
    int        bad   = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pickFwd(input logic [1:0] sel, input logic [31:0] regVal,
                                            input logic [31:0] exm, input logic [31:0] mwb);
        if (sel == 2'd1) return exm;
        if (sel == 2'd2) return mwb;
        return regVal;
    endfunction

    // Reference decode: returns {illegal, opcode}.
    function automatic logic [3:0] refDecode(input logic [1:0] op, input logic [5:0] fn);
        if (op == 2'd0) return 4'b0_010;
        if (op == 2'd1) return 4'b0_110;
        if (op == 2'd3) return 4'b0_111;
        if (fn == 6'd32) return 4'b0_010;
        if (fn == 6'd34) return 4'b0_110;
        if (fn == 6'd36) return 4'b0_000;
        if (fn == 6'd37) return 4'b0_001;
        if (fn == 6'd42) return 4'b0_111;
        return 4'b1_011;
    endfunction

    task automatic resetModel();
        refQ.delete();
        shown  = '{a: 32'd0, b: 32'd0, sd: 32'd0, opc: 3'd0, ill: 1'b0};
        refCnt = 0;
    endtask

    task automatic checkState();
        checkOutput("out_valid", 32'(out_valid), 32'(refQ.size() > 0));
        checkOutput("in_ready", 32'(in_ready), 32'(refQ.size() < 2));
        checkOutput("alu_a", alu_a, shown.a);
        checkOutput("alu_b", alu_b, shown.b);
        checkOutput("store_data", store_data, shown.sd);
        checkOutput("alu_opc", 32'(alu_opc), 32'(shown.opc));
        checkOutput("illegal", 32'(illegal), 32'(shown.ill));
        checkOutput("illegal_cnt", 32'(illegal_cnt), 32'(refCnt));
    endtask

    // Apply the inputs currently driven for one clock, advance the model,
    // then check the DUT on the following falling edge.
    task automatic applyStimulus();
        refEntry_t  e;
        logic [3:0] dec;
        bit         doPush;
        bit         doPop;
        doPush = in_valid && (refQ.size() < 2);
        doPop  = out_ready && (refQ.size() > 0);
        dec    = refDecode(alu_op, funct);
        e.a    = pickFwd(fwd_a, rs_data, ex_mem_res, mem_wb_res);
        e.sd   = pickFwd(fwd_b, rt_data, ex_mem_res, mem_wb_res);
        e.b    = alu_src ? imm : e.sd;
        e.opc  = dec[2:0];
        e.ill  = dec[3];
        if (flush) begin
            refQ.delete();
        end else begin
            if (doPop) void'(refQ.pop_front());
            if (doPush) begin
                refQ.push_back(e);
                if (e.ill && refCnt < CNT_MAX) refCnt++;
            end
        end
        if (refQ.size() > 0) shown = refQ[0];
        @(posedge clk);
        @(negedge clk);
        checkState();
    endtask

    task automatic setOp(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt);
        alu_op  = op;
        funct   = fn;
        rs_data = rs;
        rt_data = rt;
        fwd_a   = 2'd0;
        fwd_b   = 2'd0;
        alu_src = 1'b0;
    endtask

    initial begin
        rst = 1'b1;  in_valid = 1'b0; alu_op = 2'd0; funct = 6'd0;
        rs_data = '0; rt_data = '0; imm = '0; alu_src = 1'b0;
        fwd_a = 2'd0; fwd_b = 2'd0; ex_mem_res = '0; mem_wb_res = '0;
        flush = 1'b0; out_ready = 1'b0;
        resetModel();
        @(negedge clk);
        checkState();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        // R-type sub with an empty queue
        out_ready = 1'b1; in_valid = 1'b1;
        setOp(2'b10, 6'b100010, 32'd7, 32'd3);
        applyStimulus();
        checkOutput("rtype_opc", 32'(alu_opc), 32'b110);
        checkOutput("rtype_a", alu_a, 32'd7);
        checkOutput("rtype_b", alu_b, 32'd3);
        in_valid = 1'b0;
        applyStimulus();
        checkOutput("rtype_retired", 32'(out_valid), 32'd0);

        // Forwarding plus immediate, then forward sources change under a held entry
        out_ready = 1'b0; in_valid = 1'b1;
        setOp(2'b00, 6'd0, 32'hDEAD, 32'hBEEF);
        fwd_a = 2'b01; ex_mem_res = 32'h100;
        fwd_b = 2'b10; mem_wb_res = 32'h55;
        alu_src = 1'b1; imm = 32'hFFFF_FFFC;
        applyStimulus();
        checkOutput("fwd_a", alu_a, 32'h100);
        checkOutput("fwd_b_imm", alu_b, 32'hFFFF_FFFC);
        checkOutput("fwd_store", store_data, 32'h55);
        in_valid = 1'b0; ex_mem_res = 32'h999; mem_wb_res = 32'h777;
        applyStimulus();
        checkOutput("fwd_hold", alu_a, 32'h100);
        out_ready = 1'b1;
        applyStimulus();

        // Backpressure: A, B accepted, C held by ID until space frees
        out_ready = 1'b0; in_valid = 1'b1;
        setOp(2'b00, 6'd0, 32'hA, 32'h1);
        applyStimulus();
        rs_data = 32'hB;
        applyStimulus();
        checkOutput("bp_full", 32'(in_ready), 32'd0);
        rs_data = 32'hC;
        applyStimulus();
        checkOutput("bp_head_a", alu_a, 32'hA);
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("bp_head_b", alu_a, 32'hB);
        applyStimulus();
        checkOutput("bp_head_c", alu_a, 32'hC);
        in_valid = 1'b0;
        applyStimulus();

        // Illegal funct
        in_valid = 1'b1;
        setOp(2'b10, 6'b000111, 32'h11, 32'h22);
        applyStimulus();
        checkOutput("ill_opc", 32'(alu_opc), 32'b011);
        checkOutput("ill_flag", 32'(illegal), 32'd1);
        checkOutput("ill_cnt1", 32'(illegal_cnt), 32'd1);
        in_valid = 1'b0;
        applyStimulus();

        // Flush with full queue, competing illegal push and pop
        out_ready = 1'b0; in_valid = 1'b1;
        setOp(2'b01, 6'd0, 32'h5, 32'h6);
        applyStimulus();
        applyStimulus();
        flush = 1'b1; out_ready = 1'b1;
        setOp(2'b10, 6'b111111, 32'h7, 32'h8);
        applyStimulus();
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_ready", 32'(in_ready), 32'd1);
        checkOutput("flush_cnt", 32'(illegal_cnt), 32'd1);
        flush = 1'b0;

        // Counter saturation: five illegal pushes in total
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("ill_sat", 32'(illegal_cnt), 32'd3);
        in_valid = 1'b0;
        applyStimulus();

        // Asynchronous reset between edges with a full queue
        out_ready = 1'b0; in_valid = 1'b1;
        setOp(2'b11, 6'd0, 32'h1234, 32'h5678);
        applyStimulus();
        applyStimulus();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_a", alu_a, 32'd0);
        checkOutput("arst_b", alu_b, 32'd0);
        checkOutput("arst_sd", store_data, 32'd0);
        checkOutput("arst_opc", 32'(alu_opc), 32'd0);
        checkOutput("arst_cnt", 32'(illegal_cnt), 32'd0);
        resetModel();
        @(negedge clk);
        rst = 1'b0;
        checkState();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(3) != 0);
            out_ready  = ($urandom_range(2) != 0);
            flush      = ($urandom_range(15) == 0);
            alu_op     = 2'($urandom_range(3));
            case ($urandom_range(5))
                0: funct = 6'd32;
                1: funct = 6'd34;
                2: funct = 6'd36;
                3: funct = 6'd37;
                4: funct = 6'd42;
                default: funct = 6'($urandom);
            endcase
            rs_data    = $urandom;
            rt_data    = $urandom;
            imm        = $urandom;
            ex_mem_res = $urandom;
            mem_wb_res = $urandom;
            alu_src    = 1'($urandom);
            fwd_a      = 2'($urandom);
            fwd_b      = 2'($urandom);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
